// File: rtl/io_bus_bridge_if.sv
// MMIO bus bundle between the core (master) and io_bus_bridge (slave).
interface io_bus_bridge_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              bus_cs;
    logic              bus_wr;
    logic              bus_rd;
    logic [31:0]       bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_ready;
    logic              bus_err;
    logic              bus_busy;

    modport master (
        output bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data,
        input  bus_rd_data, bus_ready, bus_err, bus_busy
    );

    modport slave (
        input  bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data,
        output bus_rd_data, bus_ready, bus_err, bus_busy
    );
endinterface

// File: rtl/io_bus_bridge.sv
// Registered MMIO-to-slot bridge: decodes the bus address into NUM_SLOTS slots,
// strobes only the selected slot, waits for its ready with a timeout and returns
// a one-cycle bus_ready/bus_err completion.
// Optional error-capture registers are compiled in with `define IO_ERR_CAPTURE_EN.
module io_bus_bridge #(
    parameter int unsigned          NUM_SLOTS    = 16,
    parameter int unsigned          REG_ADDR_W   = 5,
    parameter int unsigned          DATA_W       = 32,
    parameter int unsigned          TIMEOUT_CYC  = 256,
    parameter logic [NUM_SLOTS-1:0] SLOT_EN_MASK = '1,
    parameter logic [DATA_W-1:0]    ERR_DATA     = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    io_bus_bridge_if.slave        bus,
    output logic [NUM_SLOTS-1:0]  slot_cs_array,
    output logic [NUM_SLOTS-1:0]  slot_mem_rd_array,
    output logic [NUM_SLOTS-1:0]  slot_mem_wr_array,
    output logic [REG_ADDR_W-1:0] slot_reg_addr,
    output logic [DATA_W-1:0]     slot_wr_data,
    input  logic [DATA_W-1:0]     slot_rd_data_array [NUM_SLOTS],
    input  logic [NUM_SLOTS-1:0]  slot_ready_array
`ifdef IO_ERR_CAPTURE_EN
    ,
    input  logic                  err_clr,
    output logic                  err_valid,
    output logic [31:0]           err_addr,
    output logic                  err_is_timeout
`endif
);
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                state_q;
    logic [SLOT_W-1:0]     slot_q;
    logic                  rd_op_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_SLOTS-1:0]  slot_cs_q;
    logic [NUM_SLOTS-1:0]  slot_rd_q;
    logic [NUM_SLOTS-1:0]  slot_wr_q;
    logic [REG_ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  busy_q;

    logic [SLOT_W-1:0]     req_slot;
    logic [REG_ADDR_W-1:0] req_reg;
    logic [NUM_SLOTS-1:0]  req_onehot;
    logic                  req_ok;
    logic                  req_bad;
    logic                  sel_ready;
    logic                  timeout;
    logic                  unused_addr;

    assign req_reg    = bus.bus_addr[REG_ADDR_W+1:2];
    assign req_slot   = bus.bus_addr[REG_ADDR_W+SLOT_W+1:REG_ADDR_W+2];
    assign req_onehot = NUM_SLOTS'(1) << req_slot;
    // Upper address bits only matter to the optional error capture.
    assign unused_addr = ^bus.bus_addr;

    // Exactly one op to a populated slot is accepted; both ops, or any op to an
    // unpopulated slot, completes immediately with an error. cs with no op is ignored.
    assign req_ok  = bus.bus_cs && (bus.bus_rd ^ bus.bus_wr) && SLOT_EN_MASK[req_slot];
    assign req_bad = bus.bus_cs && ((bus.bus_rd && bus.bus_wr) ||
                     ((bus.bus_rd || bus.bus_wr) && !SLOT_EN_MASK[req_slot]));

    assign sel_ready = slot_ready_array[slot_q];
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Bridge FSM; all bus and slot outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            slot_q     <= '0;
            rd_op_q    <= 1'b0;
            cnt_q      <= '0;
            slot_cs_q  <= '0;
            slot_rd_q  <= '0;
            slot_wr_q  <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_bad) begin
                        state_q <= StDone;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        // Any rejected request with rd set counts as an errored read.
                        if (bus.bus_rd) begin
                            rd_data_q <= ERR_DATA;
                        end
                    end else if (req_ok) begin
                        state_q    <= StAccess;
                        busy_q     <= 1'b1;
                        slot_q     <= req_slot;
                        rd_op_q    <= bus.bus_rd;
                        cnt_q      <= '0;
                        reg_addr_q <= req_reg;
                        wr_data_q  <= bus.bus_wr_data;
                        slot_cs_q  <= req_onehot;
                        slot_rd_q  <= bus.bus_rd ? req_onehot : '0;
                        slot_wr_q  <= bus.bus_wr ? req_onehot : '0;
                    end
                end
                StAccess: begin
                    // Ready in the timeout cycle still completes cleanly.
                    if (sel_ready || timeout) begin
                        state_q   <= StDone;
                        slot_cs_q <= '0;
                        slot_rd_q <= '0;
                        slot_wr_q <= '0;
                        ready_q   <= 1'b1;
                        err_q     <= !sel_ready;
                        if (rd_op_q) begin
                            rd_data_q <= sel_ready ? slot_rd_data_array[slot_q] : ERR_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.bus_rd_data  = rd_data_q;
    assign bus.bus_ready    = ready_q;
    assign bus.bus_err      = err_q;
    assign bus.bus_busy     = busy_q;
    assign slot_cs_array     = slot_cs_q;
    assign slot_mem_rd_array = slot_rd_q;
    assign slot_mem_wr_array = slot_wr_q;
    assign slot_reg_addr     = reg_addr_q;
    assign slot_wr_data      = wr_data_q;

`ifdef IO_ERR_CAPTURE_EN
    logic [31:0] req_addr_q;
    logic        err_valid_q;
    logic [31:0] err_addr_q;
    logic        err_timeout_q;
    logic        err_event;
    logic        err_event_timeout;

    assign err_event_timeout = (state_q == StAccess) && timeout && !sel_ready;
    assign err_event         = ((state_q == StIdle) && req_bad) || err_event_timeout;

    // Sticky first-error capture; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_q    <= '0;
            err_valid_q   <= 1'b0;
            err_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if ((state_q == StIdle) && req_ok) begin
                req_addr_q <= bus.bus_addr;
            end
            if (err_event && (!err_valid_q || err_clr)) begin
                err_valid_q   <= 1'b1;
                err_addr_q    <= err_event_timeout ? req_addr_q : bus.bus_addr;
                err_timeout_q <= err_event_timeout;
            end else if (err_clr) begin
                err_valid_q <= 1'b0;
            end
        end
    end

    assign err_valid      = err_valid_q;
    assign err_addr       = err_addr_q;
    assign err_is_timeout = err_timeout_q;
`endif

endmodule
